// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone responder over a word-organised RAM with fixed response latency.
// Define WB_MEM_RANDOM_STALL_EN to add LFSR-driven pseudo-random stalls for stress testing.
module wb_mem_responder #(
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int DepthWords     = 1024,
  parameter int Latency        = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bus_cyc,
  input  logic                     bus_stb,
  input  logic                     bus_we,
  input  logic [AddrWidth-1:0]     bus_addr,
  input  logic [DataWidth/8-1:0]   bus_sel,
  input  logic [DataWidth-1:0]     bus_data_m,
  output logic [DataWidth-1:0]     bus_data_s,
  output logic                     bus_ack,
  output logic                     bus_err,
  output logic                     bus_stall
);

  localparam int SelWidth = DataWidth / 8;
  localparam int MemAw    = (DepthWords > 1) ? $clog2(DepthWords) : 1;
  localparam int CntWidth = $clog2(MaxOutstanding + 1);

  localparam logic [CntWidth-1:0]  CntMax     = CntWidth'(MaxOutstanding);
  localparam logic [AddrWidth-1:0] DepthLimit = AddrWidth'(DepthWords);

  logic [DataWidth-1:0] mem [DepthWords];

  logic [CntWidth-1:0]  count;
  logic [Latency-1:0]   pipe_valid;
  logic [Latency-1:0]   pipe_err;
  logic [DataWidth-1:0] pipe_data [Latency];

  logic                 accept;
  logic                 req_err;
  logic                 load_out;
  logic                 out_valid;
  logic                 out_err;
  logic [AddrWidth-1:0] word_idx;
  logic [MemAw-1:0]     mem_idx;
  logic [DataWidth-1:0] rd_data;
  logic [Latency:0]     valid_chain;
  logic [Latency:0]     err_chain;

  assign word_idx = bus_addr >> 2;
  assign mem_idx  = word_idx[MemAw-1:0];
  assign req_err  = (bus_addr[1:0] != 2'b00) || (word_idx >= DepthLimit);
  assign accept   = bus_cyc && bus_stb && !bus_stall;

  // Writes and errors carry zero data so the response path never needs to know the request type.
  assign rd_data  = (bus_we || req_err) ? '0 : mem[mem_idx];

  // Element 0 is the request being accepted this edge; element Latency is the response stage.
  assign valid_chain = {pipe_valid, accept};
  assign err_chain   = {pipe_err, req_err};
  assign out_valid   = valid_chain[Latency];
  assign out_err     = err_chain[Latency];

  // A request stops counting once it reaches the response stage, so Latency outstanding slots suffice
  // for back-to-back traffic.
  assign load_out    = valid_chain[Latency-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      count      <= '0;
    end else if (!bus_cyc) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      count      <= '0;
    end else begin
      pipe_valid <= valid_chain[Latency-1:0];
      pipe_err   <= err_chain[Latency-1:0];
      if (accept && !load_out) begin
        count <= count + 1'b1;
      end else if (!accept && load_out) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_data[0] <= rd_data;
    for (int i = 1; i < Latency; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus_we && !req_err) begin
      for (int i = 0; i < SelWidth; i++) begin
        if (bus_sel[i]) begin
          mem[mem_idx][8*i +: 8] <= bus_data_m[8*i +: 8];
        end
      end
    end
  end

  // Gating with bus_cyc hides a response already in the output stage when the master aborts.
  assign bus_ack    = bus_cyc && out_valid && !out_err;
  assign bus_err    = bus_cyc && out_valid && out_err;
  assign bus_data_s = bus_ack ? pipe_data[Latency-1] : '0;

`ifdef WB_MEM_RANDOM_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign bus_stall = (count == CntMax) || (lfsr[2:0] == 3'b000);
`else
  assign bus_stall = (count == CntMax);
`endif

endmodule
